// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master round-robin arbiter and sequencer for a
// single-port RAM with combinational read and write on the rising clock edge.
// Master 0 is the CPU bus, master 1 the DMA/boot-loader port.
// Optional macro MEM_ARB_LOCK_EN adds m0_lock, letting master 0 keep the bus
// across back-to-back accesses (atomic read-modify-write, bursts).
module mem_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic                  m0_lock,
`endif
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write_en,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,

    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GRANT0 = 3'd1,
        GRANT1 = 3'd2,
        DONE0  = 3'd3,
        DONE1  = 3'd4
    } state_t;

    state_t state;
    state_t next_state;
    logic   last_grant;
    logic   write_en_q;

    // Lock request from master 0; constant low when the feature is compiled out.
    logic   m0_locked;
`ifdef MEM_ARB_LOCK_EN
    assign m0_locked = m0_lock;
`else
    assign m0_locked = 1'b0;
`endif

    // Next-state: round-robin in IDLE, hand-over to the other master from DONE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    next_state = last_grant ? GRANT0 : GRANT1;
                end else if (m0_req) begin
                    next_state = GRANT0;
                end else if (m1_req) begin
                    next_state = GRANT1;
                end
            end
            GRANT0: next_state = DONE0;
            GRANT1: next_state = DONE1;
            DONE0: begin
                if (m0_locked && m0_req) begin
                    next_state = GRANT0;
                end else if (m1_req) begin
                    next_state = GRANT1;
                end else begin
                    next_state = IDLE;
                end
            end
            DONE1: begin
                if (m0_req) begin
                    next_state = GRANT0;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register, arbitration history, handshake and status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state  <= next_state;
            m0_ack <= (next_state == DONE0);
            m1_ack <= (next_state == DONE1);
            busy   <= (next_state != IDLE);
            if (state == GRANT0) begin
                last_grant <= 1'b0;
            end else if (state == GRANT1) begin
                last_grant <= 1'b1;
            end
        end
    end

    // RAM drive: loaded on entry to GRANTx so the bus is stable for the whole
    // grant cycle; address and data hold outside a grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_address <= '0;
            mem_data_in <= '0;
            write_en_q  <= 1'b0;
        end else if (next_state == GRANT0) begin
            mem_address <= m0_addr;
            mem_data_in <= m0_wdata;
            write_en_q  <= m0_we;
        end else if (next_state == GRANT1) begin
            mem_address <= m1_addr;
            mem_data_in <= m1_wdata;
            write_en_q  <= m1_we;
        end else begin
            write_en_q  <= 1'b0;
        end
    end

    // Reset kills a write in the very cycle it is asserted, not one edge later.
    assign mem_write_en = write_en_q & ~reset;

    // Read data capture at the closing edge of a read grant; writes leave it alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            if (state == GRANT0 && !write_en_q) begin
                m0_rdata <= mem_data_out;
            end
            if (state == GRANT1 && !write_en_q) begin
                m1_rdata <= mem_data_out;
            end
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port 64K x 8 system RAM (combinational read, write on rising clock edge).
- Master 0 is the CPU bus; master 1 is the DMA/boot-loader port.
- Serialises accesses with a req/ack handshake and round-robin fairness.
- Drives the RAM address, write enable and write data; returns registered read data.

Parameters:
- ADDR_WIDTH, 16, address width of the RAM and of both masters.
- DATA_WIDTH, 8, data width.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 access request; held until m0_ack.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_addr  in  ADDR_WIDTH  master 0 address.
- m0_wdata  in  DATA_WIDTH  master 0 write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  DATA_WIDTH  read data; valid while m0_ack=1.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as the m0_* set, for master 1.
- mem_address  out  ADDR_WIDTH  to RAM address.
- mem_write_en  out  1  to RAM write enable.
- mem_data_in  out  DATA_WIDTH  to RAM write data.
- mem_data_out  in  DATA_WIDTH  from RAM read data (combinational).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, last_grant=1 (so master 0 wins the first tie), m0_ack=m1_ack=0, m0_rdata=m1_rdata=0.
- Output defaults at reset: mem_address=0, mem_data_in=0, mem_write_en=0.
- mem_write_en is forced to 0 in any cycle where reset=1, regardless of state.
- States: IDLE, GRANT0, GRANT1, DONE0, DONE1.
- IDLE:
  - Only m0_req -> GRANT0; only m1_req -> GRANT1.
  - Both requesting -> grant the master != last_grant.
  - Neither -> stay in IDLE.
- GRANTx (exactly 1 cycle):
  - mem_address=mx_addr; mem_data_in=mx_wdata; mem_write_en=mx_we.
  - At the closing edge: the RAM write commits; mx_rdata <= mem_data_out (captured on reads; holds its previous value on writes); last_grant <= x.
  - Next state: DONEx.
- DONEx (1 cycle):
  - mx_ack=1 (registered); mx_rdata is stable.
  - mx_req is ignored in this cycle.
  - Other master requesting -> GRANT of the other master; else -> IDLE.
  - Net effect: the same master can re-win no earlier than via IDLE, and alternation is guaranteed under contention.
- Outside GRANTx: mem_write_en=0; mem_address and mem_data_in hold their last value (no glitch writes).
- Latency and throughput:
  - Request seen in IDLE: ack arrives 2 cycles later.
  - Peak rate: one access per 2 cycles; under contention, alternating accesses back to back.
- Master rules: hold req/we/addr/wdata stable from assertion until the ack cycle. A request still asserted after the ack cycle is a new access.
- Dropping req before ack is illegal; behaviour in that case is unspecified, but the arbiter must not deadlock.
- Reset mid-access: the state returns to IDLE at the next edge and no ack is issued. A write in the reset cycle is suppressed.

Optional Feature:
- Macro MEM_ARB_LOCK_EN.
- When defined:
  - Adds input m0_lock (1 bit).
  - In DONE0 with m0_lock=1 and m0_req=1 (a new request), go directly to GRANT0, ignoring m1_req. This gives the CPU atomic read-modify-write and burst sequences.
  - last_grant stays 0 during the lock. When lock drops, normal round-robin resumes and master 1 wins the next tie.
- When undefined: no m0_lock port; pure round-robin as above.

Test Plan:
- Single read: preload RAM[0xFF00]=0x01; m0 read 0xFF00 from IDLE -> m0_ack high exactly 2 cycles later, m0_rdata=0x01, m1_ack stays 0.
- Single write: m1 writes 0x48 to 0x5A00 -> mem_write_en high for exactly one cycle (GRANT1) with address 0x5A00; a later m0 read of 0x5A00 returns 0x48.
- Contention after reset: both request on the same cycle -> m0 acked first, then m1 two cycles later. Hold both asserted continuously -> acks alternate m0, m1, m0, m1 at a 2-cycle spacing.
- Reset mid-access: assert reset during GRANT1 of a write of 0x65 to 0x1234 -> RAM[0x1234] unchanged (0xFF); no m1_ack; busy=0 on the cycle after reset.
- Write-then-read hazard: m0 writes 0x6C to 0x0010, then reads 0x0010 immediately after its ack -> m0_rdata=0x6C.
- MEM_ARB_LOCK_EN: m0_lock=1 with m1_req held, m0 does 3 back-to-back accesses -> 3 m0 acks before any m1 ack. Drop lock -> next grant goes to m1.
